// File: rtl/mlp_result_tx.sv
// rtl/mlp_result_tx.sv - buffers MLP accumulator pairs and streams them as checksummed UART byte frames
module mlp_result_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mlp_acc_valid,
  input  logic signed [31:0]            mlp_acc0,
  input  logic signed [31:0]            mlp_acc1,
  input  logic [2:0]                    mlp_current_layer,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      frame_q [11];
  logic [7:0]      frame_d [11];
  logic [7:0]      new_frame [11];
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            overflow_q, overflow_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [66:0]     mem_q [FIFO_DEPTH];
  logic [66:0]     head;
  logic [7:0]      chk;
  logic            full, accept, last, pop, push, drop;

  always_comb begin
    head = mem_q[rd_ptr_q];
    new_frame[0] = SYNC_BYTE;
    new_frame[1] = {5'b0, head[66:64]};
    for (int k = 0; k < 4; k++) begin
      new_frame[2 + k] = head[8*k +: 8];
      new_frame[6 + k] = head[32 + 8*k +: 8];
    end
    chk = 8'h00;
    for (int k = 0; k < 10; k++) begin
      chk = chk ^ new_frame[k];
    end
    new_frame[10] = chk;

    full   = (count_q == CW'(FIFO_DEPTH));
    accept = tx_valid_q && tx_ready;
    last   = accept && (byte_idx_q == 4'd10);
    // A pop at the end of a frame lets a full FIFO still accept a same-edge push.
    pop    = (count_q != '0) && ((state_q == IDLE) || last);
    push   = mlp_acc_valid && (!full || pop);
    drop   = mlp_acc_valid && full && !pop;

    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    frame_d    = frame_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (pop) begin
      state_d    = SEND;
      byte_idx_d = 4'd0;
      frame_d    = new_frame;
      tx_data_d  = new_frame[0];
      tx_valid_d = 1'b1;
    end else if (last) begin
      state_d    = IDLE;
      byte_idx_d = 4'd0;
      tx_data_d  = 8'h00;
      tx_valid_d = 1'b0;
    end else if (accept) begin
      byte_idx_d = byte_idx_q + 4'd1;
      tx_data_d  = frame_q[byte_idx_q + 4'd1];
    end

    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = drop | (overflow_q & ~clear_overflow);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_idx_q <= 4'd0;
      frame_q    <= '{default: 8'h00};
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      frame_q    <= frame_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {mlp_current_layer, mlp_acc1, mlp_acc0};
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign busy       = (state_q == SEND) || (count_q != '0);

endmodule

// File: tb/tb_mlp_result_tx.sv
// tb/tb_mlp_result_tx.sv - directed and randomized checks of mlp_result_tx against a frame-level byte model
module tb_mlp_result_tx;

  logic               clk;
  logic               reset;
  logic               mlp_acc_valid;
  logic signed [31:0] mlp_acc0;
  logic signed [31:0] mlp_acc1;
  logic [2:0]         mlp_current_layer;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic [2:0]         fifo_count;
  logic               overflow;
  logic               clear_overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] golden [11];

  mlp_result_tx #(.FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk               (clk),
    .reset             (reset),
    .mlp_acc_valid     (mlp_acc_valid),
    .mlp_acc0          (mlp_acc0),
    .mlp_acc1          (mlp_acc1),
    .mlp_current_layer (mlp_current_layer),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .fifo_count        (fifo_count),
    .overflow          (overflow),
    .clear_overflow    (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; records accepted bytes and checks the output holds under backpressure.
  task automatic cyc();
    logic pv, pr, rs;
    logic [7:0] pd;
    pv = tx_valid;
    pr = tx_ready;
    pd = tx_data;
    rs = reset;
    @(posedge clk);
    #1;
    if (rs && pv && pr) got_q.push_back(pd);
    if (rs && reset && pv && !pr) begin
      check("hold_valid", tx_valid, 1);
      check("hold_data", tx_data, pd);
    end
  endtask

  task automatic model_frame(input logic [2:0] layer, input logic [31:0] a0, input logic [31:0] a1);
    logic [7:0] f [11];
    logic [7:0] x;
    f[0] = 8'hA5;
    f[1] = 8'(layer);
    for (int k = 0; k < 4; k++) begin
      f[2 + k] = 8'(a0 >> (8 * k));
      f[6 + k] = 8'(a1 >> (8 * k));
    end
    x = 8'h00;
    for (int k = 0; k < 10; k++) x = x ^ f[k];
    f[10] = x;
    for (int k = 0; k < 11; k++) exp_q.push_back(f[k]);
  endtask

  task automatic push(input logic [2:0] l, input logic [31:0] a0, input logic [31:0] a1, input bit expect_sent);
    mlp_acc_valid     = 1'b1;
    mlp_current_layer = l;
    mlp_acc0          = a0;
    mlp_acc1          = a1;
    cyc();
    mlp_acc_valid = 1'b0;
    if (expect_sent) model_frame(l, a0, a1);
  endtask

  task automatic drain(input bit rnd, input string tag);
    int n;
    n = 0;
    while ((busy || tx_valid) && n < 2000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
    end
    check({tag, "_drained"}, busy, 0);
    tx_ready = 1'b1;
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int gaps;
    golden = '{8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hAF};
    reset = 1'b0;
    mlp_acc_valid = 1'b0;
    mlp_acc0 = '0;
    mlp_acc1 = '0;
    mlp_current_layer = '0;
    tx_ready = 1'b1;
    clear_overflow = 1'b0;

    cyc();
    cyc();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    cyc();

    // Single frame with exact two-cycle latency and 11 consecutive bytes
    push(3'd2, 32'h12345678, 32'hFFFFFFFF, 0);
    check("lat_count", fifo_count, 1);
    check("lat_valid_early", tx_valid, 0);
    cyc();
    for (int i = 0; i < 11; i++) begin
      check("single_valid", tx_valid, 1);
      check("single_byte", tx_data, golden[i]);
      cyc();
    end
    check("single_end_valid", tx_valid, 0);
    check("single_end_data", tx_data, 0);
    check("single_end_busy", busy, 0);
    got_q.delete();

    // Same frame under random backpressure
    tx_ready = 1'($urandom_range(0, 1));
    push(3'd2, 32'h12345678, 32'hFFFFFFFF, 0);
    for (int i = 0; i < 11; i++) exp_q.push_back(golden[i]);
    drain(1, "bp");
    compare("bp");

    // Random traffic kept below the full threshold so nothing is dropped
    for (int c = 0; c < 300; c++) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (fifo_count < 3 && $urandom_range(0, 2) == 0)
        push(3'($urandom), $urandom, $urandom, 1);
      else
        cyc();
    end
    drain(1, "rnd");
    compare("rnd");
    check("rnd_overflow", overflow, 0);

    // Overflow: first entry goes to the frame register, 1..4 fill the FIFO, 5 is dropped
    tx_ready = 1'b0;
    push(3'd1, 32'hCAFE0000, $urandom, 1);
    for (int i = 1; i <= 5; i++) push(3'd3, 32'(i), $urandom, i <= 4);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    tx_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 55; i++) begin
      if (!tx_valid) gaps++;
      cyc();
    end
    check("ovf_b2b_gaps", gaps, 0);
    check("ovf_end_valid", tx_valid, 0);
    check("ovf_sticky", overflow, 1);
    compare("ovf");
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Push on the same edge byte10 is accepted with the FIFO full
    tx_ready = 1'b0;
    push(3'd4, $urandom, $urandom, 1);
    for (int i = 0; i < 4; i++) push(3'd5, $urandom, $urandom, 1);
    check("sim_full", fifo_count, 4);
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    push(3'd6, $urandom, $urandom, 1);
    check("sim_count", fifo_count, 4);
    check("sim_no_ovf", overflow, 0);
    drain(0, "sim");
    compare("sim");

    // Clear and drop on the same edge: set wins
    tx_ready = 1'b0;
    push(3'd7, $urandom, $urandom, 1);
    for (int i = 0; i < 4; i++) push(3'd0, $urandom, $urandom, 1);
    clear_overflow = 1'b1;
    push(3'd1, $urandom, $urandom, 0);
    clear_overflow = 1'b0;
    check("clr_drop_flag", overflow, 1);
    check("clr_drop_count", fifo_count, 4);
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    check("clr_only", overflow, 0);
    drain(1, "clr");
    compare("clr");

    // Reset after byte 4 accepted, with another entry still queued
    tx_ready = 1'b1;
    push(3'd2, $urandom, $urandom, 0);
    push(3'd3, $urandom, $urandom, 0);
    for (int i = 0; i < 5; i++) cyc();
    reset = 1'b0;
    cyc();
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", tx_data, 0);
    reset = 1'b1;
    got_q.delete();
    cyc();
    check("post_rst_idle", tx_valid, 0);
    push(3'd5, $urandom, $urandom, 1);
    drain(0, "post_rst");
    compare("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
